pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised successor to the fixed EX/MEM latch: one elastic pipeline stage.
//  Carries a control vector and a data payload with a valid/ready handshake,
//  synchronous flush (CLR) and a 2-entry skid so back-pressure never drops data.
//  Instantiated between any two CPU stages (ID/EX, EX/MEM, MEM/WB); stall/flush come from the hazard unit.
// PARAMETERS
//  DATA_W        32  payload width (ALU result, R1/R2, PC, Instr, concatenated)
//  CTRL_W        6   control-bit width (RegWrite, MemWrite, MemToReg, JAL, HalfW, Syscall, ...)
//  ZERO_ON_FLUSH 1   1: CLR also zeroes stored payload; 0: payload kept, only valid/ctrl cleared
//  CNT_W         16  stall-counter width (used only with PIPE_STALL_CNT_EN)
// PORTS
//  CLK        in   1       clock, rising edge
//  RST_N      in   1       asynchronous active-low reset
//  CLR        in   1       synchronous flush, highest priority after reset
//  IN_VALID   in   1       upstream entry valid
//  IN_READY   out  1       stage can accept; registered (= !skid_valid)
//  IN_CTRL    in   CTRL_W  upstream control bits
//  IN_DATA    in   DATA_W  upstream payload
//  OUT_VALID  out  1       head entry valid
//  OUT_READY  in   1       downstream accepts head
//  OUT_CTRL   out  CTRL_W  head control, forced 0 whenever OUT_VALID=0 (bubble = no side effects)
//  OUT_DATA   out  DATA_W  head payload
//  OCC        out  2       occupancy 0..2
//  STALL_CNT  out  CNT_W   only with PIPE_STALL_CNT_EN
// BEHAVIOUR
//  - Reset (RST_N=0, async): both slots invalid, all data/ctrl 0; OUT_VALID=0, IN_READY=1, OCC=0, STALL_CNT=0.
//  - Transfer in: IN_VALID & IN_READY at edge. Transfer out: OUT_VALID & OUT_READY at edge.
//  - States EMPTY(occ0), HEAD(occ1), FULL(occ2):
//    EMPTY: in -> HEAD (head<=in). No out possible.
//    HEAD : in&out -> HEAD (head<=in); in only -> FULL (skid<=in); out only -> EMPTY; none -> HEAD.
//    FULL : IN_READY=0; out -> HEAD (head<=skid); else hold.
//  - Latency: 1 cycle IN->OUT when empty; full throughput 1/cycle with OUT_READY=1.
//  - Ordering strictly FIFO; no entry duplicated or lost under any READY pattern.
//  - CLR=1: next state EMPTY regardless of in/out this cycle; an input offered in the
//    CLR cycle is dropped; ctrl zeroed; payload zeroed iff ZERO_ON_FLUSH=1. IN_READY=1 next cycle.
//  - Reset asserted mid-transfer: immediate clear, no partial update survives.
//  - OUT_DATA/OUT_CTRL stable while OUT_VALID=1 & OUT_READY=0.
//  - No combinational path IN_* -> OUT_* or OUT_READY -> IN_READY.
// CONFIGURATION
//  PIPE_STALL_CNT_EN defined: STALL_CNT increments each cycle OUT_VALID=1 & OUT_READY=0,
//   saturates at all-ones, cleared by RST_N only (not by CLR).
//  Undefined: STALL_CNT port and counter absent; no other behaviour change.
// STRUCTURE
//  - Shared package pipe_pkg: occ_state_e {EMPTY,HEAD,FULL}, OCC_W=2 constant,
//    default DATA_W/CTRL_W constants per stage (EX_MEM_DATA_W=160, EX_MEM_CTRL_W=6).
//  - Sub-module pipe_slot: one valid+ctrl+data register with load/clear inputs; instantiated twice (head, skid).
//  - Top holds FSM, muxing of head load source (IN vs skid), ctrl gating, optional counter.
// TESTING
//  1 Reset: RST_N low mid-stream with occ=2 -> OUT_VALID=0, OUT_CTRL=0, IN_READY=1, OCC=0 immediately.
//  2 Streaming: IN_DATA=1..8 every cycle, OUT_READY=1 -> OUT_DATA 1..8 on consecutive cycles, 1-cycle lag.
//  3 Back-pressure: OUT_READY=0 for 3 cycles while sending A,B,C -> A,B stored, OCC=2, IN_READY=0,
//    C held upstream; release -> A,B,C out in order, none lost.
//  4 Flush: occ=2, CLR=1 with IN_VALID=1 data D -> next cycle OCC=0, OUT_VALID=0, D never appears;
//    ZERO_ON_FLUSH=1 -> OUT_DATA=0.
//  5 Ctrl gating: IN_CTRL=6'b000100 then bubble -> OUT_CTRL=6'b000100 one cycle, then 0 while OUT_VALID=0.
//  6 PIPE_STALL_CNT_EN, CNT_W=4: OUT_READY=0 with head valid for 20 cycles -> STALL_CNT=15 (saturated);
//    CLR keeps 15; RST_N -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: occupancy states and per-stage widths.
package pipe_pkg;

  localparam int unsigned OCC_W         = 2;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_CTRL_W    = 6;
  localparam int unsigned EX_MEM_DATA_W = 160;
  localparam int unsigned EX_MEM_CTRL_W = 6;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    HEAD  = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of an elastic stage: valid + ctrl + data with flush/load/unload.
module pipe_slot #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CTRL_W        = 6,
  parameter int unsigned ZERO_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Flush beats load beats unload; ctrl is cleared whenever the slot empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (ZERO_ON_FLUSH != 0) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end else if (unload) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with 2-entry skid, synchronous flush and valid/ready handshake.
// Optional saturating stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned CTRL_W        = DEF_CTRL_W,
  parameter int unsigned ZERO_ON_FLUSH = 1
`ifdef PIPE_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W         = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [OCC_W-1:0]  OCC
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  STALL_CNT
`endif
);

  occ_state_e        state_q, state_d;
  logic              head_valid, skid_valid;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ld_ctrl;
  logic [DATA_W-1:0] head_data, skid_data, head_ld_data;
  logic              in_fire, out_fire;
  logic              head_load, head_from_skid, head_unload;
  logic              skid_load, skid_unload;

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = head_valid & OUT_READY;

  // Next occupancy and slot control; flush overrides any transfer this cycle.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    head_unload    = 1'b0;
    skid_load      = 1'b0;
    skid_unload    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          head_load = 1'b1;
          state_d   = HEAD;
        end
      end
      HEAD: begin
        if (in_fire && out_fire) begin
          head_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          head_unload = 1'b1;
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          skid_unload    = 1'b1;
          state_d        = HEAD;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (CLR) state_d = EMPTY;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign head_ld_ctrl = head_from_skid ? skid_ctrl : IN_CTRL;
  assign head_ld_data = head_from_skid ? skid_data : IN_DATA;

  pipe_slot #(
    .DATA_W        (DATA_W),
    .CTRL_W        (CTRL_W),
    .ZERO_ON_FLUSH (ZERO_ON_FLUSH)
  ) u_head (
    .clk     (CLK),
    .rst_n   (RST_N),
    .flush   (CLR),
    .load    (head_load),
    .unload  (head_unload),
    .ld_ctrl (head_ld_ctrl),
    .ld_data (head_ld_data),
    .valid   (head_valid),
    .ctrl    (head_ctrl),
    .data    (head_data)
  );

  pipe_slot #(
    .DATA_W        (DATA_W),
    .CTRL_W        (CTRL_W),
    .ZERO_ON_FLUSH (ZERO_ON_FLUSH)
  ) u_skid (
    .clk     (CLK),
    .rst_n   (RST_N),
    .flush   (CLR),
    .load    (skid_load),
    .unload  (skid_unload),
    .ld_ctrl (IN_CTRL),
    .ld_data (IN_DATA),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  // A bubble must never carry side-effecting control bits downstream.
  assign OUT_VALID = head_valid;
  assign OUT_CTRL  = head_valid ? head_ctrl : '0;
  assign OUT_DATA  = head_data;
  assign IN_READY  = ~skid_valid;
  assign OCC       = state_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of stalled head cycles; survives flush, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                         stall_q <= '0;
    else if (head_valid && !OUT_READY && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
  end

  assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: directed stimulus, queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 6;

  logic              CLK = 1'b0;
  logic              RST_N, CLR, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [CTRL_W-1:0] IN_CTRL, OUT_CTRL;
  logic [DATA_W-1:0] IN_DATA, OUT_DATA;
  logic [1:0]        OCC;
`ifdef PIPE_STALL_CNT_EN
  logic [3:0]        STALL_CNT;
`endif

  always #5 CLK = ~CLK;

  pipe_stage_elastic #(
    .DATA_W        (DATA_W),
    .CTRL_W        (CTRL_W),
    .ZERO_ON_FLUSH (1)
`ifdef PIPE_STALL_CNT_EN
    ,
    .CNT_W         (4)
`endif
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CLR       (CLR),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_CTRL   (IN_CTRL),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_CTRL  (OUT_CTRL),
    .OUT_DATA  (OUT_DATA),
    .OCC       (OCC)
`ifdef PIPE_STALL_CNT_EN
    ,
    .STALL_CNT (STALL_CNT)
`endif
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_flushed = 1'b1;
  bit    m_in_fire, m_out_fire;
  int    m_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic clr);
    @(negedge CLK);
    IN_VALID  = v;
    IN_CTRL   = c;
    IN_DATA   = d;
    OUT_READY = ordy;
    CLR       = clr;
  endtask

  // Monitor: compare DUT against the model mid-cycle, then advance the model at the edge.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      m_in_fire  = 1'b0;
      m_out_fire = 1'b0;
      if (!RST_N) begin
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_in_ready",  64'(IN_READY),  64'd1);
        check("rst_occ",       64'(OCC),       64'd0);
        check("rst_out_ctrl",  64'(OUT_CTRL),  64'd0);
`ifdef PIPE_STALL_CNT_EN
        check("rst_stall_cnt", 64'(STALL_CNT), 64'd0);
`endif
        sb_q.delete();
        m_flushed = 1'b1;
        m_stall   = 0;
      end else begin
        check("occ",       64'(OCC),       64'(sb_q.size()));
        check("in_ready",  64'(IN_READY),  64'(sb_q.size() < 2));
        check("out_valid", 64'(OUT_VALID), 64'(sb_q.size() > 0));
        if (sb_q.size() > 0) begin
          check("out_data", 64'(OUT_DATA), 64'(sb_q[0].data));
          check("out_ctrl", 64'(OUT_CTRL), 64'(sb_q[0].ctrl));
        end else begin
          check("bubble_ctrl", 64'(OUT_CTRL), 64'd0);
          if (m_flushed) check("flushed_data", 64'(OUT_DATA), 64'd0);
        end
`ifdef PIPE_STALL_CNT_EN
        check("stall_cnt", 64'(STALL_CNT), 64'(m_stall));
`endif
        m_out_fire = (sb_q.size() > 0) && OUT_READY;
        m_in_fire  = IN_VALID && (sb_q.size() < 2);
      end
      @(posedge CLK);
      if (RST_N) begin
        if (sb_q.size() > 0 && !OUT_READY && m_stall < 15) m_stall++;
        if (CLR) begin
          sb_q.delete();
          m_flushed = 1'b1;
        end else begin
          if (m_out_fire) void'(sb_q.pop_front());
          if (m_in_fire) begin
            sb_q.push_back({IN_CTRL, IN_DATA});
            m_flushed = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    RST_N = 1'b0; CLR = 1'b0; IN_VALID = 1'b0; IN_CTRL = '0; IN_DATA = '0; OUT_READY = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // Streaming 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) drive(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
    repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Back-pressure: A,B stored, C held upstream, then drained in order
    drive(1'b1, 6'h01, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 6'h02, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 6'h03, 32'hC, 1'b0, 1'b0);
    #3;
    check("bp_occ_full",     64'(OCC),      64'd2);
    check("bp_in_ready_low", 64'(IN_READY), 64'd0);
    check("bp_head_is_a",    64'(OUT_DATA), 64'hA);
    drive(1'b1, 6'h03, 32'hC, 1'b1, 1'b0);
    drive(1'b1, 6'h03, 32'hC, 1'b1, 1'b0);
    repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Ctrl gating: one valid entry then bubbles
    drive(1'b1, 6'b000100, 32'h55, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #3;
    check("gate_ctrl_valid", 64'(OUT_CTRL), 64'h4);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #3;
    check("gate_ctrl_bubble", 64'(OUT_CTRL), 64'h0);

    // Flush with occ=2 while D is offered
    drive(1'b1, 6'h01, 32'hE, 1'b0, 1'b0);
    drive(1'b1, 6'h02, 32'hF, 1'b0, 1'b0);
    drive(1'b1, 6'h03, 32'hD, 1'b0, 1'b1);
    #3;
    check("flush_pre_occ", 64'(OCC), 64'd2);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #3;
    check("flush_occ",       64'(OCC),       64'd0);
    check("flush_out_valid", 64'(OUT_VALID), 64'd0);
    check("flush_out_data",  64'(OUT_DATA),  64'd0);
    check("flush_in_ready",  64'(IN_READY),  64'd1);
    repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef PIPE_STALL_CNT_EN
    // Stall counter: saturate, survive flush, clear on reset
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    drive(1'b1, 6'h01, 32'h77, 1'b0, 1'b0);
    repeat (21) drive(1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    check("stall_saturated", 64'(STALL_CNT), 64'd15);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    check("stall_after_clr", 64'(STALL_CNT), 64'd15);
    RST_N = 1'b0;
    #1;
    check("stall_after_rst", 64'(STALL_CNT), 64'd0);
    @(negedge CLK); RST_N = 1'b1;
`endif

    // Asynchronous reset mid-stream with occ=2
    drive(1'b1, 6'h01, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 6'h02, 32'h22, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge CLK);
    #2;
    check("pre_rst_occ", 64'(OCC), 64'd2);
    RST_N = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("async_rst_out_ctrl",  64'(OUT_CTRL),  64'd0);
    check("async_rst_in_ready",  64'(IN_READY),  64'd1);
    check("async_rst_occ",       64'(OCC),       64'd0);
    @(negedge CLK);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    RST_N = 1'b1;

    // Short stream after reset, then drain
    drive(1'b1, 6'h05, 32'h99, 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);
    #3;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
